// File: rtl/video_line_fetch.sv
// Line prefetcher between the video timing generator and the panel: fills a ping-pong
// line buffer from framebuffer memory and emits pixels/syncs one cycle behind the timing inputs.
// Optional colour-bar overlay is enabled by defining VIDEO_LINE_FETCH_TESTPAT_EN.
module video_line_fetch #(
  parameter int HRes     = 480,
  parameter int VRes     = 272,
  parameter int PixW     = 16,
  parameter int AddrW    = 17,
  parameter int BaseAddr = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic             in_de,
  input  logic [9:0]       in_sx,
  input  logic [9:0]       in_sy,
`ifdef VIDEO_LINE_FETCH_TESTPAT_EN
  input  logic             tp_en,
`endif
  output logic             mem_req,
  output logic [AddrW-1:0] mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [PixW-1:0]  mem_rdata,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic             out_de,
  output logic [PixW-1:0]  out_rgb,
  output logic             underrun
);

  localparam int XW = (HRes > 1) ? $clog2(HRes) : 1;
  localparam int CW = $clog2(HRes + 1);
  localparam logic [9:0]       SxLast   = 10'(HRes - 1);
  localparam logic [9:0]       SyLast   = 10'(VRes - 1);
  localparam logic [9:0]       SxEnd    = 10'(HRes);
  localparam logic [CW-1:0]    CntLast  = CW'(HRes - 1);
  localparam logic [CW-1:0]    CntFull  = CW'(HRes);
  localparam logic [AddrW-1:0] BaseC    = AddrW'(BaseAddr);
  localparam logic [AddrW-1:0] LineStep = AddrW'(HRes);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    issue_cnt, ret_cnt;
  logic [AddrW-1:0] line_base;
  logic             tgt;
  logic [1:0]       line_ready;
  logic             t_line, t_frame, trig, trig_tgt, ret_we;
  logic             line_start, ready_now, blank_nx, blank_q;
  logic [XW-1:0]    rd_idx;
  logic [PixW-1:0]  rd_q;
  logic [PixW-1:0]  lbuf [2][HRes];

  // out_vsync holds last cycle's in_vsync, so it doubles as the edge detector.
  assign t_line   = (in_sx == SxLast) && (in_sy < SyLast);
  assign t_frame  = out_vsync && !in_vsync;
  assign trig     = t_line || t_frame;
  assign trig_tgt = t_frame ? 1'b0 : ~in_sy[0];

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    ret_we   = 1'b0;
    case (state)
      IDLE: begin
        if (trig) state_nx = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        ret_we  = mem_rvalid;
        if (mem_gnt && (issue_cnt == CntLast)) state_nx = DRAIN;
      end
      DRAIN: begin
        ret_we = mem_rvalid;
        if (ret_cnt == CntFull) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (ret_cnt == CntFull) ret_we = 1'b0;
  end

  // line_base tracks every line trigger, even ignored ones, so addresses stay aligned with in_sy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      mem_addr   <= BaseC;
      line_base  <= BaseC;
      tgt        <= 1'b0;
      line_ready <= 2'b00;
    end else begin
      state <= state_nx;
      if (t_frame)
        line_base <= BaseC + LineStep;
      else if (t_line)
        line_base <= line_base + LineStep;
      if ((state == IDLE) && trig) begin
        tgt                  <= trig_tgt;
        issue_cnt            <= '0;
        ret_cnt              <= '0;
        mem_addr             <= t_frame ? BaseC : line_base;
        line_ready[trig_tgt] <= 1'b0;
      end
      if (mem_req && mem_gnt) begin
        issue_cnt <= issue_cnt + CW'(1);
        mem_addr  <= mem_addr + AddrW'(1);
      end
      if (ret_we) ret_cnt <= ret_cnt + CW'(1);
      if (state == DONE) line_ready[tgt] <= 1'b1;
    end
  end

  assign rd_idx = (in_sx < SxEnd) ? in_sx[XW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (ret_we) lbuf[tgt][ret_cnt[XW-1:0]] <= mem_rdata;
    rd_q <= lbuf[in_sy[0]][rd_idx];
  end

  // Readiness is decided once at the first active pixel and held for the whole line.
  assign line_start = in_de && (in_sx == 10'd0);
  assign ready_now  = line_ready[in_sy[0]] || ((state == DONE) && (tgt == in_sy[0]));
  assign blank_nx   = line_start ? !ready_now : blank_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_hsync <= 1'b1;
      out_vsync <= 1'b1;
      out_de    <= 1'b0;
      blank_q   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      out_hsync <= in_hsync;
      out_vsync <= in_vsync;
      out_de    <= in_de;
      blank_q   <= blank_nx;
      if ((line_start && !ready_now) || (trig && (state != IDLE))) underrun <= 1'b1;
    end
  end

`ifdef VIDEO_LINE_FETCH_TESTPAT_EN
  logic [2:0]      bar_idx;
  logic [PixW-1:0] bar_rgb, bar_q;
  logic            tp_q;

  // Bar index = in_sx*8/HRes, found by comparing against the seven bar boundaries.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({3'b000, in_sx, 3'b000} >= 16'(k * HRes)) bar_idx = bar_idx + 3'd1;
    end
    case (bar_idx)
      3'd0:    bar_rgb = PixW'(16'hFFFF);
      3'd1:    bar_rgb = PixW'(16'hFFE0);
      3'd2:    bar_rgb = PixW'(16'h07FF);
      3'd3:    bar_rgb = PixW'(16'h07E0);
      3'd4:    bar_rgb = PixW'(16'hF81F);
      3'd5:    bar_rgb = PixW'(16'hF800);
      3'd6:    bar_rgb = PixW'(16'h001F);
      default: bar_rgb = PixW'(16'h0000);
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tp_q  <= 1'b0;
      bar_q <= '0;
    end else begin
      tp_q  <= tp_en;
      bar_q <= bar_rgb;
    end
  end

  assign out_rgb = !out_de ? '0 : (tp_q ? bar_q : (blank_q ? '0 : rd_q));
`else
  assign out_rgb = (out_de && !blank_q) ? rd_q : '0;
`endif

endmodule

// File: tb/tb_video_line_fetch.sv
// Directed bench for video_line_fetch: small 8x4 raster, framebuffer word k holds k.
// Colour-bar checks are compiled in when VIDEO_LINE_FETCH_TESTPAT_EN is defined.
`timescale 1ns/1ps
module tb_video_line_fetch;

  localparam int HRes  = 8;
  localparam int VRes  = 4;
  localparam int PixW  = 16;
  localparam int AddrW = 17;
  localparam int HT    = 32;
  localparam int VT    = 8;

  logic             clk;
  logic             rstn;
  logic             in_hsync, in_vsync, in_de;
  logic [9:0]       in_sx, in_sy;
  logic             mem_req, mem_gnt, mem_rvalid;
  logic [AddrW-1:0] mem_addr;
  logic [PixW-1:0]  mem_rdata;
  logic             out_hsync, out_vsync, out_de, underrun;
  logic [PixW-1:0]  out_rgb;
`ifdef VIDEO_LINE_FETCH_TESTPAT_EN
  logic             tp_en;
  logic [15:0]      bars [8];
`endif

  int vectors = 0;
  int errors  = 0;
  int lat      = 3;
  int gnt_mode = 0;
  int cyc      = 0;
  int sx = 0, sy = VRes, frame = 0;
  int due_q[$];
  int dat_q[$];

  video_line_fetch #(
    .HRes(HRes), .VRes(VRes), .PixW(PixW), .AddrW(AddrW), .BaseAddr(0)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .in_sx(in_sx), .in_sy(in_sy),
`ifdef VIDEO_LINE_FETCH_TESTPAT_EN
    .tp_en(tp_en),
`endif
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
    .out_rgb(out_rgb), .underrun(underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Timing generator and memory model, both updated at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        sx = 0; sy = VRes; frame = 0;
        due_q.delete();
        dat_q.delete();
      end else begin
        sx++;
        if (sx == HT) begin
          sx = 0; sy++;
          if (sy == VT) begin sy = 0; frame++; end
        end
      end
      in_sx    = 10'(sx);
      in_sy    = 10'(sy);
      in_de    = (sx < HRes) && (sy < VRes);
      in_hsync = !((sx >= 12) && (sx < 16));
      in_vsync = !(sy == 5);
      mem_gnt  = (gnt_mode == 0) ? 1'b1 : cyc[0];
      if (rstn && mem_req && mem_gnt) begin
        due_q.push_back(cyc + lat);
        dat_q.push_back(int'(mem_addr));
      end
      if (rstn && (due_q.size() > 0) && (due_q[0] == cyc)) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'(dat_q[0]);
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'hDEAD;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_pos(input int f, input int y, input int x, output bit ok);
    ok = 1'b0;
    for (int n = 0; (n < 3000) && !ok; n++) begin
      @(negedge clk); #1;
      if ((frame == f) && (sy == y) && (sx == x)) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    wait_pos(1, 1, 10, ok);
    vectors++;
    if (!ok) begin errors++; $display("[TB] FAIL reset_wait: got=%0b want=1", ok); end
    rstn = 1'b0;
    #1;
    vectors += 7;
    if (out_hsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_hsync: got=%b want=1", out_hsync); end
    if (out_vsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_vsync: got=%b want=1", out_vsync); end
    if (out_de !== 1'b0)    begin errors++; $display("[TB] FAIL reset_de: got=%b want=0", out_de); end
    if (out_rgb !== 16'h0)  begin errors++; $display("[TB] FAIL reset_rgb: got=%h want=0000", out_rgb); end
    if (mem_req !== 1'b0)   begin errors++; $display("[TB] FAIL reset_req: got=%b want=0", mem_req); end
    if (mem_addr !== 17'd0) begin errors++; $display("[TB] FAIL reset_addr: got=%h want=0", mem_addr); end
    if (underrun !== 1'b0)  begin errors++; $display("[TB] FAIL reset_underrun: got=%b want=0", underrun); end
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic test_display();
    bit ok;
    int p;
    logic exp_de, exp_hs;
    logic [15:0] exp_rgb;
    wait_pos(2, 1, 0, ok);
    vectors++;
    if (!ok) begin errors++; $display("[TB] FAIL display_wait: got=%0b want=1", ok); end
    for (int i = 1; i <= HT; i++) begin
      @(negedge clk); #1;
      p       = i - 1;
      exp_de  = (p < HRes);
      exp_hs  = !((p >= 12) && (p < 16));
      exp_rgb = exp_de ? 16'(HRes + p) : 16'h0;
      vectors += 4;
      if (out_de !== exp_de)     begin errors++; $display("[TB] FAIL display_de sx=%0d: got=%b want=%b", p, out_de, exp_de); end
      if (out_hsync !== exp_hs)  begin errors++; $display("[TB] FAIL display_hsync sx=%0d: got=%b want=%b", p, out_hsync, exp_hs); end
      if (out_vsync !== 1'b1)    begin errors++; $display("[TB] FAIL display_vsync sx=%0d: got=%b want=1", p, out_vsync); end
      if (out_rgb !== exp_rgb)   begin errors++; $display("[TB] FAIL display_rgb sx=%0d: got=%h want=%h", p, out_rgb, exp_rgb); end
    end
    wait_pos(2, 5, 0, ok);
    vectors += 3;
    if (!ok) begin errors++; $display("[TB] FAIL vsync_wait: got=%0b want=1", ok); end
    if (out_vsync !== 1'b1) begin errors++; $display("[TB] FAIL vsync_before: got=%b want=1", out_vsync); end
    @(negedge clk); #1;
    if (out_vsync !== 1'b0) begin errors++; $display("[TB] FAIL vsync_after: got=%b want=0", out_vsync); end
    vectors++;
    if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL display_underrun: got=%b want=0", underrun); end
  endtask

  task automatic test_gnt_toggle();
    bit ok;
    int grants;
    logic [16:0] exp_addr;
    wait_pos(3, 1, 0, ok);
    vectors++;
    if (!ok) begin errors++; $display("[TB] FAIL toggle_wait: got=%0b want=1", ok); end
    gnt_mode = 1;
    grants   = 0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk); #1;
      if ((sy == 1) && mem_req) begin
        exp_addr = 17'(2 * HRes + grants);
        vectors++;
        if (mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL toggle_addr grant=%0d: got=%h want=%h", grants, mem_addr, exp_addr); end
        if (mem_gnt) grants++;
      end
      if ((sy == 2) && (sx >= 1) && (sx <= HRes)) begin
        vectors++;
        if (out_rgb !== 16'(2 * HRes + sx - 1)) begin
          errors++; $display("[TB] FAIL toggle_rgb sx=%0d: got=%h want=%h", sx - 1, out_rgb, 16'(2 * HRes + sx - 1));
        end
      end
    end
    gnt_mode = 0;
    vectors += 2;
    if (grants != HRes)    begin errors++; $display("[TB] FAIL toggle_grants: got=%0d want=%0d", grants, HRes); end
    if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL toggle_underrun: got=%b want=0", underrun); end
  endtask

  task automatic test_underrun_latency();
    bit ok;
    wait_pos(3, 6, 0, ok);
    vectors += 2;
    if (!ok) begin errors++; $display("[TB] FAIL lat_wait: got=%0b want=1", ok); end
    if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL lat_underrun_before: got=%b want=0", underrun); end
    lat = 40;
    wait_pos(4, 1, 0, ok);
    vectors++;
    if (!ok) begin errors++; $display("[TB] FAIL lat_wait_line1: got=%0b want=1", ok); end
    for (int i = 1; i <= HRes; i++) begin
      @(negedge clk); #1;
      vectors += 3;
      if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL lat_underrun sx=%0d: got=%b want=1", i - 1, underrun); end
      if (out_de !== 1'b1)   begin errors++; $display("[TB] FAIL lat_de sx=%0d: got=%b want=1", i - 1, out_de); end
      if (out_rgb !== 16'h0) begin errors++; $display("[TB] FAIL lat_rgb sx=%0d: got=%h want=0000", i - 1, out_rgb); end
    end
    wait_pos(4, 2, 0, ok);
    vectors += 2;
    if (!ok) begin errors++; $display("[TB] FAIL lat_wait_line2: got=%0b want=1", ok); end
    if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL lat_sticky: got=%b want=1", underrun); end
  endtask

  task automatic test_reset_in_drain();
    bit ok;
    bit seen;
    wait_pos(4, 2, 20, ok);
    vectors += 2;
    if (!ok) begin errors++; $display("[TB] FAIL drain_wait: got=%0b want=1", ok); end
    if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL drain_req: got=%b want=0", mem_req); end
    rstn = 1'b0;
    #1;
    vectors += 2;
    if (underrun !== 1'b0)  begin errors++; $display("[TB] FAIL drain_reset_underrun: got=%b want=0", underrun); end
    if (mem_addr !== 17'd0) begin errors++; $display("[TB] FAIL drain_reset_addr: got=%h want=0", mem_addr); end
    repeat (2) @(negedge clk);
    lat = 3;
    #2 rstn = 1'b1;
    seen = 1'b0;
    for (int n = 0; (n < 400) && !seen; n++) begin
      @(negedge clk); #1;
      if (mem_req) begin
        seen = 1'b1;
        vectors += 2;
        if (mem_addr !== 17'd0) begin errors++; $display("[TB] FAIL drain_refetch_addr: got=%h want=0", mem_addr); end
        if ((sy != 5) || (sx != 1)) begin errors++; $display("[TB] FAIL drain_refetch_pos: got=%0d/%0d want=5/1", sy, sx); end
      end
    end
    vectors++;
    if (!seen) begin errors++; $display("[TB] FAIL drain_refetch_seen: got=0 want=1"); end
    for (int ln = 0; ln < 2; ln++) begin
      wait_pos(1, ln, 0, ok);
      vectors++;
      if (!ok) begin errors++; $display("[TB] FAIL drain_wait_line%0d: got=%0b want=1", ln, ok); end
      for (int i = 1; i <= HRes; i++) begin
        @(negedge clk); #1;
        vectors++;
        if (out_rgb !== 16'(ln * HRes + i - 1)) begin
          errors++; $display("[TB] FAIL drain_rgb line=%0d sx=%0d: got=%h want=%h", ln, i - 1, out_rgb, 16'(ln * HRes + i - 1));
        end
      end
    end
    vectors++;
    if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL drain_underrun: got=%b want=0", underrun); end
  endtask

`ifdef VIDEO_LINE_FETCH_TESTPAT_EN
  task automatic test_testpat();
    bit ok;
    tp_en = 1'b1;
    for (int ln = 2; ln < 4; ln++) begin
      wait_pos(1, ln, 0, ok);
      vectors++;
      if (!ok) begin errors++; $display("[TB] FAIL tp_wait_line%0d: got=%0b want=1", ln, ok); end
      for (int i = 1; i <= HRes; i++) begin
        @(negedge clk); #1;
        vectors++;
        if (out_rgb !== bars[i - 1]) begin
          errors++; $display("[TB] FAIL tp_bar line=%0d sx=%0d: got=%h want=%h", ln, i - 1, out_rgb, bars[i - 1]);
        end
      end
    end
    tp_en = 1'b0;
  endtask
`endif

  initial begin
    rstn       = 1'b0;
    in_sx      = 10'd0;
    in_sy      = 10'(VRes);
    in_de      = 1'b0;
    in_hsync   = 1'b1;
    in_vsync   = 1'b1;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
`ifdef VIDEO_LINE_FETCH_TESTPAT_EN
    tp_en = 1'b0;
    bars  = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    $display("[TB] starting video_line_fetch bench");
    test_reset();
    test_display();
    test_gnt_toggle();
    test_underrun_latency();
    test_reset_in_drain();
`ifdef VIDEO_LINE_FETCH_TESTPAT_EN
    test_testpat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
